// File: rtl/snake_pkg.sv
// Shared encodings for the snake input scheduler: keycodes, directions, commands, states.
package snake_pkg;

   localparam logic [7:0] KEY_START  = 8'h1B;
   localparam logic [7:0] KEY_PAUSE  = 8'h4D;
   localparam logic [7:0] KEY_RESUME = 8'h2D;
   localparam logic [7:0] KEY_QUIT   = 8'h76;
   localparam logic [7:0] KEY_RIGHT  = 8'h74;
   localparam logic [7:0] KEY_UP     = 8'h75;
   localparam logic [7:0] KEY_DOWN   = 8'h72;
   localparam logic [7:0] KEY_LEFT   = 8'h6B;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_UP    = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      CMD_START  = 2'b00,
      CMD_PAUSE  = 2'b01,
      CMD_RESUME = 2'b10,
      CMD_QUIT   = 2'b11
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10,
      ST_OVER   = 2'b11
   } sched_state_t;

   // Encoding pairs right/left and up/down as bitwise complements.
   function automatic logic [1:0] opposite_dir(input logic [1:0] d);
      return ~d;
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous direction queue with flush; exposes head and tail for the reversal filter.
module dir_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk_25MHz,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [1:0] din,
   output logic       full,
   output logic       empty,
   output logic [3:0] level,
   output logic [1:0] head,
   output logic [1:0] tail
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]    DEPTH_L = 4'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [1:0]       mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    tail_ptr;
   logic [3:0]       count_reg;
   logic [DEPTH-1:0] we;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_reg == DEPTH_L);
   assign empty    = (count_reg == 4'd0);
   assign level    = count_reg;
   assign do_pop   = pop && !empty;
   // A full queue still accepts a write when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign tail_ptr = wr_ptr_reg - PTR_ONE;
   assign head     = mem_reg[rd_ptr_reg];
   assign tail     = mem_reg[tail_ptr];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
         assign we[gi] = do_push && (wr_ptr_reg == PW'(gi));
      end
   endgenerate

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= 2'b00;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) mem_reg[i] <= din;
         end
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         if (do_push && !do_pop)      count_reg <= count_reg + 4'd1;
         else if (do_pop && !do_push) count_reg <= count_reg - 4'd1;
      end
   end

endmodule

// File: rtl/snake_input_scheduler.sv
// Keycode decoder, game-state FSM, move tick divider and reversal filter in front of the
// direction queue; releases at most one queued direction per move tick.
module snake_input_scheduler
   import snake_pkg::*;
#(
   parameter int CLK_HZ     = 25_000_000,
   parameter int TICK_HZ    = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_25MHz,
   input  logic       reset,
   input  logic [7:0] keycode,
   input  logic       new_key_strobe,
   input  logic       game_over,
   output logic       cmd_valid,
   output logic [1:0] cmd,
   output logic       move_tick,
   output logic [1:0] dir,
   output logic [1:0] sched_state,
   output logic [3:0] fifo_level,
   output logic       overflow
);
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   sched_state_t  state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          cmd_valid_reg, move_tick_reg, overflow_reg;
   cmd_t          cmd_reg, key_cmd;
   logic [1:0]    dir_reg, key_dir, ref_dir;
   logic          is_ctrl, is_arrow, restart, stay_run, tick_fire, accept;
   logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [1:0]    fifo_head, fifo_tail;

   always_comb begin
      is_ctrl  = 1'b0;
      is_arrow = 1'b0;
      key_cmd  = CMD_START;
      key_dir  = DIR_RIGHT;
      if (new_key_strobe) begin
         case (keycode)
            KEY_START:  begin is_ctrl = 1'b1;  key_cmd = CMD_START;  end
            KEY_PAUSE:  begin is_ctrl = 1'b1;  key_cmd = CMD_PAUSE;  end
            KEY_RESUME: begin is_ctrl = 1'b1;  key_cmd = CMD_RESUME; end
            KEY_QUIT:   begin is_ctrl = 1'b1;  key_cmd = CMD_QUIT;   end
            KEY_RIGHT:  begin is_arrow = 1'b1; key_dir = DIR_RIGHT;  end
            KEY_UP:     begin is_arrow = 1'b1; key_dir = DIR_UP;     end
            KEY_DOWN:   begin is_arrow = 1'b1; key_dir = DIR_DOWN;   end
            KEY_LEFT:   begin is_arrow = 1'b1; key_dir = DIR_LEFT;   end
            default: ;
         endcase
      end
   end

   // A decoded control key outranks a collision reported in the same cycle.
   always_comb begin
      state_next = state_reg;
      if (is_ctrl) begin
         case (key_cmd)
            CMD_START:  state_next = ST_RUN;
            CMD_PAUSE:  if (state_reg == ST_RUN)    state_next = ST_PAUSED;
            CMD_RESUME: if (state_reg == ST_PAUSED) state_next = ST_RUN;
            default:    state_next = ST_IDLE;
         endcase
      end else if (state_reg == ST_RUN && game_over) begin
         state_next = ST_OVER;
      end
   end

   assign restart    = is_ctrl && (key_cmd == CMD_START || key_cmd == CMD_QUIT);
   assign stay_run   = (state_reg == ST_RUN) && (state_next == ST_RUN);
   assign tick_fire  = stay_run && (cnt_reg == TICK_LAST);
   assign fifo_pop   = tick_fire && !restart && !fifo_empty;
   assign fifo_flush = restart || (state_reg == ST_RUN && state_next == ST_OVER);
   // The queue tail after any same-cycle pop is unchanged unless it empties, in which
   // case the popped head (== tail) becomes dir, so the pre-pop tail is always right.
   assign ref_dir    = fifo_empty ? dir_reg : fifo_tail;
   assign accept     = is_arrow && stay_run && (key_dir != ref_dir) &&
                       (key_dir != opposite_dir(ref_dir));
   assign fifo_push  = accept && (!fifo_full || fifo_pop);
   assign cnt_next   = (stay_run && !restart && cnt_reg != TICK_LAST) ? cnt_reg + 1'b1 : '0;

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         cmd_valid_reg <= 1'b0;
         cmd_reg       <= CMD_START;
         move_tick_reg <= 1'b0;
         dir_reg       <= DIR_RIGHT;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         cmd_valid_reg <= is_ctrl;
         move_tick_reg <= tick_fire;
         if (is_ctrl) cmd_reg <= key_cmd;
         if (restart)       dir_reg <= DIR_RIGHT;
         else if (fifo_pop) dir_reg <= fifo_head;
         if (restart) overflow_reg <= 1'b0;
         else if (accept && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
      end
   end

   dir_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_dir_fifo (
      .clk_25MHz(clk_25MHz),
      .reset    (reset),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .flush    (fifo_flush),
      .din      (key_dir),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level),
      .head     (fifo_head),
      .tail     (fifo_tail)
   );

   assign cmd_valid   = cmd_valid_reg;
   assign cmd         = cmd_reg;
   assign move_tick   = move_tick_reg;
   assign dir         = dir_reg;
   assign sched_state = state_reg;
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_snake_input_scheduler.sv
// Randomized + directed bench: a queue-based game model predicts pulses (scoreboard) and levels.
module tb_snake_input_scheduler;
   localparam int CLK_HZ = 100;
   localparam int TICK_HZ = 10;
   localparam int TD = CLK_HZ / TICK_HZ;
   localparam int DEPTH = 4;

   logic       clk_25MHz = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       new_key_strobe = 1'b0;
   logic       game_over = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       move_tick;
   logic [1:0] dir;
   logic [1:0] sched_state;
   logic [3:0] fifo_level;
   logic       overflow;

   snake_input_scheduler #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_25MHz(clk_25MHz), .reset(reset), .keycode(keycode),
      .new_key_strobe(new_key_strobe), .game_over(game_over),
      .cmd_valid(cmd_valid), .cmd(cmd), .move_tick(move_tick), .dir(dir),
      .sched_state(sched_state), .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clk_25MHz = ~clk_25MHz;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk_25MHz) cyc <= cyc + 1;

   typedef struct {
      bit         is_tick;
      int         at;
      logic [1:0] val;
      logic [1:0] st;
   } ev_t;
   ev_t sb[$];

   // Game model: 0 IDLE, 1 RUN, 2 PAUSED, 3 OVER
   int         m_state = 0;
   int         m_run = 0;
   logic [1:0] m_dir = 2'b00;
   logic [1:0] m_q[$];
   bit         m_ovf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step(input bit stb, input logic [7:0] code, input bit go);
      bit ctrl, arrow, restart, tick;
      logic [1:0] c, d, r;
      int nxt;
      ev_t e;
      ctrl = 0; arrow = 0; c = 2'd0; d = 2'd0;
      if (stb) begin
         case (code)
            8'h1B: begin ctrl = 1; c = 2'd0; end
            8'h4D: begin ctrl = 1; c = 2'd1; end
            8'h2D: begin ctrl = 1; c = 2'd2; end
            8'h76: begin ctrl = 1; c = 2'd3; end
            8'h74: begin arrow = 1; d = 2'd0; end
            8'h75: begin arrow = 1; d = 2'd1; end
            8'h72: begin arrow = 1; d = 2'd2; end
            8'h6B: begin arrow = 1; d = 2'd3; end
            default: ;
         endcase
      end
      nxt = m_state;
      if (ctrl) begin
         if (c == 2'd0) nxt = 1;
         else if (c == 2'd1 && m_state == 1) nxt = 2;
         else if (c == 2'd2 && m_state == 2) nxt = 1;
         else if (c == 2'd3) nxt = 0;
      end else if (m_state == 1 && go) begin
         nxt = 3;
      end
      restart = ctrl && (c == 2'd0 || c == 2'd3);
      tick = (m_state == 1) && (nxt == 1) && ((m_run + 1) % TD == 0);
      if (restart) begin
         m_q.delete();
         m_dir = 2'b00;
         m_ovf = 0;
      end
      if (nxt == 3 && m_state != 3) m_q.delete();
      if (tick && !restart && m_q.size() > 0) m_dir = m_q.pop_front();
      if (arrow && m_state == 1 && nxt == 1) begin
         r = (m_q.size() > 0) ? m_q[$] : m_dir;
         if (d != r && (d ^ r) != 2'b11) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1;
         end
      end
      m_run = (m_state == 1 && nxt == 1 && !restart) ? m_run + 1 : 0;
      if (ctrl) begin
         e.is_tick = 0; e.at = cyc + 1; e.val = c; e.st = 2'(nxt);
         sb.push_back(e);
      end
      if (tick) begin
         e.is_tick = 1; e.at = cyc + 1; e.val = m_dir; e.st = 2'd1;
         sb.push_back(e);
      end
      m_state = nxt;
   endtask

   // Called just after a rising edge: compare levels, then apply the next cycle's inputs.
   task automatic drive(input bit stb, input logic [7:0] code, input bit go);
      check("sched_state", 32'(sched_state), 32'(m_state));
      check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("dir", 32'(dir), 32'(m_dir));
      new_key_strobe = stb;
      keycode = code;
      game_over = go;
      model_step(stb, code, go);
      @(posedge clk_25MHz);
      #1;
      new_key_strobe = 1'b0;
      game_over = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk_25MHz);
      #1;
      new_key_strobe = 1'b0;
      game_over = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd", 32'(cmd), 32'd0);
      check("rst_move_tick", 32'(move_tick), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_state", 32'(sched_state), 32'd0);
      check("rst_fifo_level", 32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      m_state = 0; m_run = 0; m_dir = 2'b00; m_ovf = 0;
      m_q.delete();
      sb.delete();
      @(posedge clk_25MHz);
      @(posedge clk_25MHz);
      #1;
      reset = 1'b0;
   endtask

   task automatic take_pulse(input bit is_tick, input logic [1:0] val);
      ev_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s: got pulse val %0d expected none (cycle %0d)",
                  is_tick ? "move_tick" : "cmd_valid", val, cyc);
         return;
      end
      e = sb.pop_front();
      check(is_tick ? "tick_kind" : "cmd_kind", 32'(is_tick), 32'(e.is_tick));
      check(is_tick ? "tick_cycle" : "cmd_cycle", 32'(cyc), 32'(e.at));
      check(is_tick ? "tick_dir" : "cmd_code", 32'(val), 32'(e.val));
      if (!is_tick) check("cmd_state", 32'(sched_state), 32'(e.st));
   endtask

   // Monitor: pops one expectation per presented pulse and flags overdue ones.
   always @(negedge clk_25MHz) begin
      if (!reset) begin
         if (cmd_valid) take_pulse(1'b0, cmd);
         if (move_tick) take_pulse(1'b1, dir);
         while (sb.size() > 0 && sb[0].at <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: got none expected %s at cycle %0d (now %0d)",
                     sb[0].is_tick ? "move_tick" : "cmd_valid", sb[0].at, cyc);
            void'(sb.pop_front());
         end
      end
   end

   logic [7:0] arrows [4];
   initial begin
      arrows[0] = 8'h74; arrows[1] = 8'h75; arrows[2] = 8'h72; arrows[3] = 8'h6B;
      do_reset();
      drive(1'b1, 8'h75, 1'b0);   // arrow in IDLE is ignored
      drive(1'b1, 8'h1B, 1'b0);
      idle(12);
      drive(1'b1, 8'h74, 1'b0);   // duplicate of dir 00
      drive(1'b1, 8'h6B, 1'b0);   // reversal of dir 00
      idle(2);
      drive(1'b1, 8'h1B, 1'b0);
      drive(1'b1, 8'h75, 1'b0);
      drive(1'b1, 8'h6B, 1'b0);
      drive(1'b1, 8'h6B, 1'b0);
      drive(1'b1, 8'h74, 1'b0);
      idle(25);
      drive(1'b1, 8'h1B, 1'b0);   // fill past depth
      for (int i = 0; i < 5; i++) drive(1'b1, (i % 2 == 0) ? 8'h75 : 8'h74, 1'b0);
      idle(1);
      drive(1'b1, 8'h1B, 1'b0);
      idle(2);
      drive(1'b1, 8'h75, 1'b0);
      drive(1'b1, 8'h4D, 1'b0);
      idle(50);
      drive(1'b1, 8'h2D, 1'b0);
      idle(12);
      drive(1'b1, 8'h6B, 1'b0);
      drive(1'b1, 8'h72, 1'b0);
      drive(1'b0, 8'h00, 1'b1);   // collision
      idle(15);
      drive(1'b1, 8'h1B, 1'b0);   // reset with three queued
      drive(1'b1, 8'h75, 1'b0);
      drive(1'b1, 8'h74, 1'b0);
      drive(1'b1, 8'h75, 1'b0);
      idle(1);
      do_reset();
      idle(3);
      drive(1'b1, 8'h1B, 1'b0);
      for (int i = 0; i < 2000; i++) begin
         int r;
         int k;
         logic [7:0] code;
         r = $urandom_range(0, 99);
         if (r < 30) begin
            drive(1'b1, arrows[$urandom_range(0, 3)], 1'b0);
         end else if (r < 33) begin
            code = 8'($urandom_range(0, 255));
            if (code == 8'h2D) code = 8'h00;
            drive(1'b1, code, 1'b0);
         end else if (r < 36) begin
            k = $urandom_range(0, 3);
            if (k == 2 && m_state == 1) k = 1;
            case (k)
               0: drive(1'b1, 8'h1B, 1'b0);
               1: drive(1'b1, 8'h4D, 1'b0);
               2: drive(1'b1, 8'h2D, 1'b0);
               default: drive(1'b1, 8'h76, 1'b0);
            endcase
         end else if (r < 37) begin
            drive(1'b0, 8'h00, 1'b1);
         end else begin
            drive(1'b0, 8'h00, 1'b0);
         end
      end
      idle(2);
      @(negedge clk_25MHz);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
